// File: rtl/smvm_stream_tx.sv
// SMVM input-protocol transmitter: scans a dense matrix into a compressed
// (val, col, last) buffer, then streams header, vector and entry beat pairs.
module smvm_stream_tx #(
  parameter int MAX_DIM = 128,
  parameter int MAX_NNZ = 256,
  parameter int ADDR_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rows_in,
  input  logic [7:0]        cols_in,
  output logic [ADDR_W-1:0] mat_addr,
  input  logic [7:0]        mat_rdata,
  output logic [6:0]        vec_addr,
  input  logic [7:0]        vec_rdata,
  output logic [7:0]        val_out,
  output logic [2:0]        col_out,
  output logic              ipv_out,
  output logic              tx_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NW = $clog2(MAX_NNZ + 1);
  localparam int IW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
  localparam int KW = (NW > 8) ? NW : 8;

  typedef enum logic [3:0] {
    S_IDLE, S_SCAN, S_DRAIN, S_HDR_R, S_HDR_C, S_VEC, S_M_VAL, S_M_IDX, S_END
  } state_t;

  state_t state_q, state_d;
  logic [7:0]        rows_q, cols_q, r_q, c_q, rd_col_q;
  logic [ADDR_W-1:0] addr_q;
  logic [6:0]        vaddr_q;
  logic [NW-1:0]     nnz_q;
  logic [KW-1:0]     k_q, k_d;
  logic              rd_vld_q, row_nz_q;
  logic [7:0]        val_q, val_d;
  logic [2:0]        col_q, col_d;
  logic              ipv_q, ipv_d, txv_q, txv_d, done_q, done_d, err_q, err_d;

  logic [7:0]         bval_q [MAX_NNZ];
  logic [6:0]         bcol_q [MAX_NNZ];
  logic [MAX_NNZ-1:0] blast_q;

  logic proc, nz, endrow, push, ovf, mark_prev, last_elem, bad_dim;
  logic [IW-1:0] widx, pidx, cidx, ridx;

  // Read data for the address issued last cycle is consumed while scanning or draining.
  assign proc      = rd_vld_q && (state_q == S_SCAN || state_q == S_DRAIN);
  assign nz        = (mat_rdata != 8'd0);
  assign endrow    = (rd_col_q == cols_q - 8'd1);
  assign push      = proc && (nz || (endrow && !row_nz_q));
  assign ovf       = push && (nnz_q == NW'(MAX_NNZ));
  assign mark_prev = proc && !push && endrow;
  assign last_elem = (r_q == rows_q - 8'd1) && (c_q == cols_q - 8'd1);
  assign bad_dim   = (rows_in == 8'd0) || (rows_in > 8'(MAX_DIM)) ||
                     (cols_in == 8'd0) || (cols_in > 8'(MAX_DIM));
  assign widx      = nnz_q[IW-1:0];
  assign pidx      = widx - IW'(1);
  assign cidx      = k_q[IW-1:0];
  assign ridx      = (state_q == S_M_IDX) ? cidx + IW'(1) : '0;

  always_ff @(posedge clk) begin
    if (push && !ovf) begin
      bval_q[widx]  <= nz ? mat_rdata : 8'd0;
      bcol_q[widx]  <= nz ? rd_col_q[6:0] : 7'd0;
      blast_q[widx] <= endrow;
    end else if (mark_prev) begin
      blast_q[pidx] <= 1'b1;
    end
  end

  // Outputs are computed for the state being entered, so each beat is registered.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    val_d   = 8'd0;
    col_d   = 3'd0;
    ipv_d   = 1'b0;
    txv_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        if (bad_dim) begin
          err_d  = 1'b1;
          done_d = 1'b1;
        end else begin
          err_d   = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN, S_DRAIN: begin
        if (ovf) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_END;
        end else if (state_q == S_DRAIN) begin
          state_d = S_HDR_R;
          val_d   = rows_q;
          txv_d   = 1'b1;
        end else if (last_elem) begin
          state_d = S_DRAIN;
        end
      end
      S_HDR_R: begin
        state_d = S_HDR_C;
        val_d   = cols_q;
        txv_d   = 1'b1;
      end
      S_HDR_C: begin
        state_d = S_VEC;
        val_d   = vec_rdata;
        txv_d   = 1'b1;
        k_d     = '0;
      end
      S_VEC: begin
        txv_d = 1'b1;
        if (k_q == KW'(cols_q - 8'd1)) begin
          state_d = S_M_VAL;
          k_d     = '0;
          val_d   = bval_q[ridx];
          ipv_d   = blast_q[ridx];
        end else begin
          val_d = vec_rdata;
          k_d   = k_q + KW'(1);
        end
      end
      S_M_VAL: begin
        state_d = S_M_IDX;
        txv_d   = 1'b1;
        val_d   = {5'd0, bcol_q[cidx][6:4]};
        ipv_d   = bcol_q[cidx][3];
        col_d   = bcol_q[cidx][2:0];
      end
      S_M_IDX: begin
        if ((k_q + KW'(1)) == KW'(nnz_q)) begin
          state_d = S_END;
          done_d  = 1'b1;
        end else begin
          state_d = S_M_VAL;
          k_d     = k_q + KW'(1);
          txv_d   = 1'b1;
          val_d   = bval_q[ridx];
          ipv_d   = blast_q[ridx];
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      cols_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      rd_col_q <= '0;
      addr_q   <= '0;
      vaddr_q  <= '0;
      nnz_q    <= '0;
      k_q      <= '0;
      rd_vld_q <= 1'b0;
      row_nz_q <= 1'b0;
      val_q    <= '0;
      col_q    <= '0;
      ipv_q    <= 1'b0;
      txv_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      val_q    <= val_d;
      col_q    <= col_d;
      ipv_q    <= ipv_d;
      txv_q    <= txv_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_vld_q <= (state_q == S_SCAN);
      rd_col_q <= c_q;
      if (state_q == S_IDLE && state_d == S_SCAN) begin
        rows_q   <= rows_in;
        cols_q   <= cols_in;
        r_q      <= '0;
        c_q      <= '0;
        addr_q   <= '0;
        vaddr_q  <= '0;
        nnz_q    <= '0;
        row_nz_q <= 1'b0;
      end
      if (state_q == S_SCAN) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (c_q == cols_q - 8'd1) begin
          c_q <= '0;
          r_q <= r_q + 8'd1;
        end else begin
          c_q <= c_q + 8'd1;
        end
      end
      if (proc) row_nz_q <= endrow ? 1'b0 : (row_nz_q | nz);
      if (push && !ovf) nnz_q <= nnz_q + NW'(1);
      // Vector address runs one beat ahead to hide the read latency.
      if (state_q inside {S_HDR_R, S_HDR_C, S_VEC}) vaddr_q <= vaddr_q + 7'd1;
    end
  end

  assign mat_addr = addr_q;
  assign vec_addr = vaddr_q;
  assign val_out  = val_q;
  assign col_out  = col_q;
  assign ipv_out  = ipv_q;
  assign tx_valid = txv_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_smvm_stream_tx.sv
// Randomized and directed bench for smvm_stream_tx against a frame-level model.
module tb_smvm_stream_tx;
  localparam int NNZ = 4;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0]  rows_in = '0, cols_in = '0;
  logic [13:0] mat_addr;
  logic [7:0]  mat_rdata, vec_rdata;
  logic [6:0]  vec_addr;
  logic [7:0]  val_out;
  logic [2:0]  col_out;
  logic        ipv_out, tx_valid, busy, done, err;

  smvm_stream_tx #(.MAX_DIM(128), .MAX_NNZ(NNZ), .ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .rows_in(rows_in), .cols_in(cols_in),
    .mat_addr(mat_addr), .mat_rdata(mat_rdata), .vec_addr(vec_addr),
    .vec_rdata(vec_rdata), .val_out(val_out), .col_out(col_out),
    .ipv_out(ipv_out), .tx_valid(tx_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0] mat [0:16383];
  logic [7:0] vec [0:127];
  always @(posedge clk) begin
    mat_rdata <= mat[mat_addr];
    vec_rdata <= vec[vec_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] got_q[$];
  int          got_cyc[$];
  int          done_cnt, done_cyc;
  logic        done_busy, done_txv, busy_after, prev_done;
  always @(negedge clk) begin
    if (tx_valid) begin
      got_q.push_back({val_out, ipv_out, col_out});
      got_cyc.push_back(cyc);
    end
    if (prev_done) busy_after = busy;
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
      done_txv  = tx_valid;
    end
    prev_done = done;
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    done_cnt   = 0;
    done_cyc   = 0;
    done_busy  = 1'b0;
    done_txv   = 1'b0;
    busy_after = 1'b1;
    prev_done  = 1'b0;
  endtask

  task automatic rand_mem(input int R, input int C, input int pct);
    logic [7:0] v;
    for (int i = 0; i < R * C; i++) begin
      v = 8'($urandom_range(255));
      if (v == 8'd0) v = 8'd1;
      mat[i] = ($urandom_range(99) < pct) ? v : 8'd0;
    end
    for (int j = 0; j < 128; j++) vec[j] = 8'($urandom_range(255));
  endtask

  task automatic zero_mat(input int n);
    for (int i = 0; i < n; i++) mat[i] = 8'd0;
  endtask

  // Model: build the entry list row by row, then the expected beat list and done time.
  task automatic run_job(input string name, input int R, input int C, input bit poke);
    logic [11:0] exp_q[$];
    logic [7:0]  ev[$];
    int          ec[$];
    bit          el[$];
    bit          legal, ovf, found;
    int          pos, exp_off, start_cyc, bound;
    logic [7:0]  v;
    legal = (R >= 1 && R <= 128 && C >= 1 && C <= 128);
    ovf = 1'b0;
    pos = 0;
    if (legal) begin
      for (int r = 0; r < R; r++) begin
        found = 1'b0;
        for (int c = 0; c < C; c++) begin
          v = mat[r * C + c];
          if (v != 8'd0) begin
            if (ec.size() == NNZ && !ovf) begin ovf = 1'b1; pos = r * C + c; end
            ev.push_back(v); ec.push_back(c); el.push_back(1'b0);
            found = 1'b1;
          end
          if (c == C - 1) begin
            if (found) el[el.size() - 1] = 1'b1;
            else begin
              if (ec.size() == NNZ && !ovf) begin ovf = 1'b1; pos = r * C + c; end
              ev.push_back(8'd0); ec.push_back(0); el.push_back(1'b1);
            end
          end
        end
      end
    end
    if (legal && !ovf) begin
      exp_q.push_back({8'(R), 4'h0});
      exp_q.push_back({8'(C), 4'h0});
      for (int j = 0; j < C; j++) exp_q.push_back({vec[j], 4'h0});
      for (int e = 0; e < ev.size(); e++) begin
        exp_q.push_back({ev[e], el[e], 3'b000});
        exp_q.push_back(12'(ec[e]));
      end
    end
    exp_off = !legal ? 1 : (ovf ? pos + 3 : R * C + 2 + exp_q.size());

    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; rows_in = 8'(R); cols_in = 8'(C); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1; rows_in = 8'd1; cols_in = 8'd1;
      @(posedge clk); #1 start = 1'b0;
    end
    bound = R * C + 2 * C + 4 * NNZ + 40;
    for (int i = 0; i < bound && done_cnt == 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({name, ".done_cnt"}, done_cnt, 1);
    chk({name, ".done_at"}, done_cyc - start_cyc, exp_off);
    chk({name, ".err"}, err, (legal && !ovf) ? 0 : 1);
    chk({name, ".done_busy"}, done_busy, legal);
    chk({name, ".busy_after"}, busy_after, 0);
    chk({name, ".done_txv"}, done_txv, 0);
    chk({name, ".nbeats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.beat%0d", name, i), got_q[i], exp_q[i]);
    if (got_q.size() > 0) begin
      chk({name, ".first_at"}, got_cyc[0] - start_cyc, R * C + 2);
      chk({name, ".contig"}, got_cyc[got_cyc.size() - 1] - got_cyc[0] + 1, got_q.size());
    end
  endtask

  task automatic reset_mid();
    int n;
    bit hit;
    zero_mat(32);
    for (int r = 0; r < 4; r++) mat[r * 8 + $urandom_range(7)] = 8'(r + 1);
    for (int j = 0; j < 128; j++) vec[j] = 8'($urandom_range(255));
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; rows_in = 8'd4; cols_in = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk); #1;
      if (tx_valid) n++;
      if (n == 5) hit = 1'b1;
    end
    chk("rst.hit", hit, 1);
    chk("rst.vec2", val_out, vec[2]);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst.proto", {val_out, col_out, ipv_out, tx_valid}, 0);
    chk("rst.ctl", {busy, done, err}, 0);
    rst = 1'b0;
    clear_mon();
    repeat (10) @(posedge clk);
    #1;
    chk("rst.quiet", got_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mat[i] = 8'd0;
    for (int j = 0; j < 128; j++) vec[j] = 8'd0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.proto", {val_out, col_out, ipv_out, tx_valid}, 0);
    chk("reset.ctl", {busy, done, err}, 0);
    chk("reset.addr", {mat_addr, vec_addr}, 0);
    rst = 1'b0;

    zero_mat(4); mat[0] = 8'd1; mat[3] = 8'hFE; vec[0] = 8'd3; vec[1] = 8'd4;
    run_job("t1", 2, 2, 1'b0);

    zero_mat(9); mat[1] = 8'd5; mat[7] = 8'h9C; vec[0] = 8'd7; vec[1] = 8'd8; vec[2] = 8'd9;
    run_job("t2", 3, 3, 1'b0);

    zero_mat(128); mat[100] = 8'd5; mat[127] = 8'd7;
    for (int j = 0; j < 128; j++) vec[j] = 8'($urandom_range(255));
    run_job("t3", 1, 128, 1'b0);

    zero_mat(8);
    mat[0] = 8'd1; mat[1] = 8'd2; mat[3] = 8'd3; mat[4] = 8'd4; mat[6] = 8'd5;
    run_job("t4", 1, 8, 1'b0);
    zero_mat(2); mat[1] = 8'd9;
    run_job("t4b", 1, 2, 1'b0);

    reset_mid();
    rand_mem(4, 8, 0);
    mat[3] = 8'h11; mat[12] = 8'h80; mat[31] = 8'hFF;
    run_job("t5", 4, 8, 1'b0);

    zero_mat(12); mat[2] = 8'd6; mat[4] = 8'hF0; mat[11] = 8'd1;
    run_job("t6", 3, 4, 1'b1);
    run_job("t6z", 0, 5, 1'b0);
    run_job("t6c", 2, 129, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int R, C;
      R = $urandom_range(5, 1);
      C = $urandom_range(6, 1);
      rand_mem(R, C, 20);
      run_job($sformatf("rnd%0d", t), R, C, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/smvm_stream_tx.md
Name: smvm_stream_tx

Overview:
- Transmitter for the SMVM serial input protocol. It drives val/col/ipv/in_valid into the SMVM core.
- Reads a dense row-major matrix and a dense vector from two synchronous-read memories.
- Compresses the matrix into an internal nonzero buffer, then emits one contiguous frame: header, vector, then (value, index) beat pairs.
- Sits between the host/testbench memory model and the SMVM core's input pins.

Parameters:
- MAX_DIM, 128, maximum rows/cols accepted.
- MAX_NNZ, 256, depth of the compressed-entry buffer. Dummy entries count against it.
- ADDR_W, 14, width of mat_addr. Must cover MAX_DIM*MAX_DIM.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle request. Sampled only in IDLE.
- rows_in  input  8  row count, legal 1..MAX_DIM. Sampled with start.
- cols_in  input  8  column count, legal 1..MAX_DIM. Sampled with start.
- mat_addr  output  ADDR_W  matrix read address, r*cols+c.
- mat_rdata  input  8  signed element. Valid 1 cycle after its address.
- vec_addr  output  7  vector read address.
- vec_rdata  input  8  signed element. Valid 1 cycle after its address.
- val_out  output  8  protocol val_in.
- col_out  output  3  protocol col_in.
- ipv_out  output  1  protocol ipv_in.
- tx_valid  output  1  protocol in_valid.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at end of job.
- err  output  1  sticky error flag. Cleared on the next accepted start.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0. State returns to IDLE; nnz count and scan counters cleared. Reset mid-job aborts immediately with no further beats.
- All protocol outputs (val_out, col_out, ipv_out, tx_valid) are registered.
- States: IDLE, SCAN, DRAIN, HDR_R, HDR_C, VEC, M_VAL, M_IDX, END.
- IDLE:
  - start=1 with rows/cols legal: latch both, clear err, go to SCAN.
  - start=1 with either count 0 or >MAX_DIM: set err, pulse done next cycle, stay IDLE, emit no beats.
  - start while busy is ignored.
- SCAN:
  - Issues mat_addr 0..R*C-1, one per cycle.
  - DRAIN consumes the final read. First HDR_R beat occurs exactly R*C+2 cycles after the start cycle.
- Compression, per element:
  - Nonzero: push entry {val, col[6:0], last=0}.
  - At c==C-1, the row's final stored entry gets last=1.
  - A row with no nonzeros pushes a dummy {val=0, col=0, last=1}, so every row yields exactly one inner product.
- Overflow: a push when nnz==MAX_NNZ sets err, aborts the scan, emits no beats, and pulses done the next cycle.
- Frame, all beats with tx_valid=1 and no gaps:
  - HDR_R: val_out=R, col_out=0, ipv_out=0.
  - HDR_C: val_out=C, col_out=0, ipv_out=0.
  - VEC: C beats, val_out=vec[j], j=0..C-1. vec_addr is prefetched so no bubble is inserted.
  - M_VAL then M_IDX for each buffered entry, in scan order.
- M_VAL beat: val_out=entry.val, ipv_out=entry.last, col_out=0.
- M_IDX beat: {val_out, ipv_out, col_out} = 12-bit zero-extended column index, i.e. col_out=col[2:0], ipv_out=col[3], val_out={1'b0, col[6:4]} zero-extended.
- END: exactly one cycle with tx_valid=0 and all protocol outputs 0. This terminates the frame. done pulses in this cycle, busy drops the next cycle.
- Total frame length: 2 + C + 2*nnz beats.

Test Plan:
1. R=2, C=2, matrix [[1,0],[0,-2]], vec [3,4].
   - Required val_out stream: 2, 2, 3, 4, 1 (ipv1), idx0, 0xFE (ipv1), idx (col1, ipv0, val0).
   - Then one tx_valid=0 cycle with done=1.
   - First beat occurs 6 cycles after start.
2. R=3, C=3, row 1 all zero, rows 0 and 2 each with one nonzero.
   - Middle pair is val=0, ipv=1, then idx all 0. Frame length 11 beats.
3. R=1, C=128, nonzeros 5 at col 100 and 7 at col 127.
   - Col 100 idx beat: col_out=4, ipv=0, val=6.
   - Col 127 idx beat: col_out=7, ipv=1, val=7.
   - First M_VAL has ipv=0, second has ipv=1.
4. MAX_NNZ=4, R=1, C=8, five nonzeros.
   - err=1, done pulses once, tx_valid never asserts.
   - A following legal start clears err.
5. rst asserted during VEC beat 2 of an R=4, C=8 job.
   - Next cycle: all outputs 0, busy=0.
   - A fresh start then produces a correct full frame.
6. start pulsed mid-SCAN is ignored with no second frame. rows_in=0 with start gives err=1, done pulse, no beats.
